bmp_window_renderer: RTL and testbench

- Pipelined bitmap-window renderer between vga_sync and the 12-bit RGB pins.
- Maps the current raster position into a rectangular window, generates the pixel-ROM address and applies a per-frame vertical scroll with wrap-around (scrolling road).
- Delays hsync, vsync and video_on so they stay aligned with the ROM read latency.
- Drives black during blanking and BG_COLOR outside the window.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/pipe_delay.sv | 28 ++
 rtl/bmp_window_renderer.sv | 126 ++++++++++++
 tb/tb_bmp_window_renderer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: active raster size, 12-bit colour layout, sideband bundle.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // Packed {blue, green, red}, 4 bits each.
  typedef logic [11:0] color_t;

  localparam int RED_LSB   = 0;
  localparam int GREEN_LSB = 4;
  localparam int BLUE_LSB  = 8;

  localparam color_t BLACK = 12'h000;

  // Raster sideband carried alongside the pixel through the pipeline.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
    logic in_win;
  } side_t;

  // Idle sideband: syncs inactive (high), no video, outside window.
  localparam side_t SIDE_IDLE = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0, in_win: 1'b0};

endpackage

// File: rtl/pipe_delay.sv
// Tick-enabled shift register of configurable width and depth, async clear to RST_VAL.
module pipe_delay #(
  parameter int             W       = 1,
  parameter int             DEPTH   = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [DEPTH];

  // Shift one place per enabled tick; clear every stage on reset.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/bmp_window_renderer.sv
// Bitmap window renderer: raster position -> ROM address with wrapped vertical
// scroll, sideband delayed to match ROM latency, registered RGB/sync outputs.
module bmp_window_renderer
  import vga_pkg::*;
#(
  parameter int          WIN_X    = 0,
  parameter int          WIN_Y    = 84,
  parameter int          IMG_W    = 640,
  parameter int          IMG_H    = 361,
  parameter int          ADDR_W   = 19,
  parameter int          ROM_LAT  = 1,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              pix_tick,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              video_on_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [9:0]        scroll_y,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic              hsync,
  output logic              vsync,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue
);

  // Window limits clipped to the visible raster so hidden pixels are never addressed.
  localparam int X_LAST = ((WIN_X + IMG_W) < H_ACTIVE) ? (WIN_X + IMG_W - 1) : (H_ACTIVE - 1);
  localparam int Y_LAST = ((WIN_Y + IMG_H) < V_ACTIVE) ? (WIN_Y + IMG_H - 1) : (V_ACTIVE - 1);

  localparam logic [9:0]        WIN_X10 = 10'(WIN_X);
  localparam logic [9:0]        WIN_Y10 = 10'(WIN_Y);
  localparam logic [9:0]        IMG_H10 = 10'(IMG_H);
  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);

  logic [9:0]        scroll_lat_q;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  side_t             side_a_q, side_a_d, side_l;
  logic [3:0]        side_l_raw;
  color_t            rgb_q, rgb_d;
  logic              hsync_q, vsync_q;

  int         px, py;
  logic       in_win;
  logic [9:0] x_off, y_off, row_sum, row;

  assign px = int'(pixel_x);
  assign py = int'(pixel_y);

  // Window membership and wrapped image row for the current raster position.
  always_comb begin
    in_win  = (px >= WIN_X) && (px <= X_LAST) && (py >= WIN_Y) && (py <= Y_LAST);
    x_off   = pixel_x - WIN_X10;
    y_off   = pixel_y - WIN_Y10;
    row_sum = y_off + scroll_lat_q;
    row     = (row_sum >= IMG_H10) ? (row_sum - IMG_H10) : row_sum;
    rom_addr_d = in_win ? (ADDR_W'(row) * IMG_W_A + ADDR_W'(x_off)) : '0;
    side_a_d   = '{hsync: hsync_in, vsync: vsync_in, video_on: video_on_in, in_win: in_win};
  end

  // Latch scroll at frame start only; out-of-range requests fall back to no scroll.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      scroll_lat_q <= '0;
    end else if (pix_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0)) begin
      scroll_lat_q <= (scroll_y >= IMG_H10) ? 10'd0 : scroll_y;
    end
  end

  // Stage A: launch ROM address and capture the matching sideband.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rom_addr_q <= '0;
      side_a_q   <= SIDE_IDLE;
    end else if (pix_tick) begin
      rom_addr_q <= rom_addr_d;
      side_a_q   <= side_a_d;
    end
  end

  pipe_delay #(
    .W       (4),
    .DEPTH   (ROM_LAT),
    .RST_VAL (SIDE_IDLE)
  ) u_side_dly (
    .clk  (clk),
    .clr  (clr),
    .en_i (pix_tick),
    .d_i  (side_a_q),
    .q_o  (side_l_raw)
  );

  assign side_l = side_t'(side_l_raw);

  // Colour select for the pixel whose ROM word is arriving now.
  always_comb begin
    rgb_d = BLACK;
    if (side_l.video_on) rgb_d = side_l.in_win ? color_t'(rom_data) : color_t'(BG_COLOR);
  end

  // Output stage: register colour and syncs together so they stay aligned.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rgb_q   <= BLACK;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else if (pix_tick) begin
      rgb_q   <= rgb_d;
      hsync_q <= side_l.hsync;
      vsync_q <= side_l.vsync;
    end
  end

  assign rom_addr = rom_addr_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign red      = rgb_q[RED_LSB   +: 4];
  assign green    = rgb_q[GREEN_LSB +: 4];
  assign blue     = rgb_q[BLUE_LSB  +: 4];

endmodule

// File: tb/tb_bmp_window_renderer.sv
// Directed scoreboard bench for bmp_window_renderer (defaults, non-black background).
module tb_bmp_window_renderer;

  localparam logic [11:0] BG = 12'h3C5;

  logic        clk = 1'b0;
  logic        clr;
  logic        pix_tick;
  logic [9:0]  pixel_x, pixel_y, scroll_y;
  logic        video_on_in, hsync_in, vsync_in;
  logic [18:0] rom_addr;
  logic [11:0] rom_data;
  logic        hsync, vsync;
  logic [3:0]  red, green, blue;

  logic [11:0] rom_q = 12'h000;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } exp_t;

  exp_t        exp_q[$];
  int          scroll_m;
  logic [18:0] last_addr_m;

  bmp_window_renderer #(
    .WIN_X(0), .WIN_Y(84), .IMG_W(640), .IMG_H(361),
    .ADDR_W(19), .ROM_LAT(1), .BG_COLOR(BG)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .pix_tick    (pix_tick),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .video_on_in (video_on_in),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .scroll_y    (scroll_y),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .hsync       (hsync),
    .vsync       (vsync),
    .red         (red),
    .green       (green),
    .blue        (blue)
  );

  always #5 clk = ~clk;

  // One-tick synchronous pixel ROM with an easily predicted content pattern.
  function automatic logic [11:0] rom_fn(input logic [18:0] a);
    return a[11:0] ^ 12'h9A6;
  endfunction

  always @(posedge clk) if (pix_tick) rom_q <= rom_fn(rom_addr);
  assign rom_data = rom_q;

  function automatic bit win_m(input int x, input int y);
    return (x >= 0) && (x <= 639) && (y >= 84) && (y <= 444);
  endfunction

  function automatic logic [18:0] addr_m(input int x, input int y, input int s);
    int row;
    if (!win_m(x, y)) return 19'd0;
    row = (y - 84 + s) % 361;
    return 19'(row * 640 + x);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic prime_idle();
    exp_t e;
    exp_q.delete();
    e.hs = 1'b1; e.vs = 1'b1; e.rgb = 12'h000;
    exp_q.push_back(e);
    exp_q.push_back(e);
  endtask

  // Drive one raster position, idle 'gap' clocks without tick, then tick once and check.
  task automatic step(input int x, input int y, input bit von, input bit hs, input bit vs,
                      input int gap);
    exp_t        e;
    logic [18:0] ea;
    pixel_x = 10'(x); pixel_y = 10'(y);
    video_on_in = von; hsync_in = hs; vsync_in = vs;
    ea = addr_m(x, y, scroll_m);
    e.hs = hs; e.vs = vs;
    e.rgb = !von ? 12'h000 : (win_m(x, y) ? rom_fn(ea) : BG);
    if (x == 0 && y == 0) scroll_m = (int'(scroll_y) >= 361) ? 0 : int'(scroll_y);
    exp_q.push_back(e);
    if (gap > 0) begin
      pix_tick = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      chk("hold_addr", 32'(rom_addr), 32'(last_addr_m));
    end
    pix_tick = 1'b1;
    @(posedge clk); #1;
    if (gap > 0) pix_tick = 1'b0;
    chk($sformatf("addr x=%0d y=%0d", x, y), 32'(rom_addr), 32'(ea));
    last_addr_m = ea;
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      chk("hsync", 32'(hsync), 32'(e.hs));
      chk("vsync", 32'(vsync), 32'(e.vs));
      chk("rgb", 32'({blue, green, red}), 32'(e.rgb));
    end
  endtask

  initial begin
    clr = 1'b0; pix_tick = 1'b1;
    pixel_x = '0; pixel_y = '0; scroll_y = '0;
    video_on_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    scroll_m = 0; last_addr_m = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_rgb", 32'({blue, green, red}), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    clr = 1'b1;
    prime_idle();

    // Frame 1, no scroll.
    step(0, 0, 1, 1, 1, 0);
    step(5, 84, 1, 1, 1, 0);
    step(6, 84, 1, 1, 1, 0);
    step(639, 84, 1, 1, 1, 0);
    step(640, 84, 0, 1, 1, 0);
    step(10, 200, 1, 1, 1, 0);
    // Scroll request mid-frame must not apply yet.
    scroll_y = 10'd100;
    step(0, 84, 1, 1, 1, 0);
    step(0, 83, 1, 1, 1, 0);
    step(0, 445, 1, 1, 1, 0);
    step(0, 83, 0, 1, 1, 0);
    step(0, 445, 0, 1, 1, 0);
    step(20, 300, 1, 0, 1, 0);

    // Frame 2, scroll 100 with wrap.
    step(0, 0, 1, 1, 1, 0);
    step(0, 84, 1, 1, 1, 0);
    step(0, 345, 1, 1, 1, 0);
    step(3, 344, 1, 1, 1, 0);
    step(639, 444, 1, 1, 1, 0);
    step(1, 345, 1, 1, 0, 0);

    // Frame 3, out-of-range scroll falls back to 0.
    scroll_y = 10'd400;
    step(0, 0, 1, 1, 1, 0);
    step(0, 84, 1, 1, 1, 0);
    step(7, 90, 1, 1, 1, 0);

    // Frame 4, sparse pixel tick (1 in 4 clocks) with an hsync pulse.
    scroll_y = 10'd0;
    step(0, 0, 1, 1, 1, 3);
    step(100, 100, 1, 1, 1, 3);
    step(101, 100, 1, 0, 1, 3);
    step(102, 100, 1, 0, 1, 3);
    step(103, 100, 1, 1, 1, 3);
    step(104, 100, 0, 1, 0, 3);
    step(105, 100, 1, 1, 1, 3);
    step(106, 100, 1, 1, 1, 3);

    // Mid-line reset: outputs clear asynchronously, scroll drops to 0.
    scroll_y = 10'd50;
    step(0, 0, 1, 1, 1, 0);
    step(200, 150, 1, 1, 1, 0);
    step(201, 150, 1, 1, 1, 0);
    #2;
    clr = 1'b0;
    #1;
    chk("midrst_rgb", 32'({blue, green, red}), 32'd0);
    chk("midrst_hsync", 32'(hsync), 32'd1);
    chk("midrst_vsync", 32'(vsync), 32'd1);
    chk("midrst_addr", 32'(rom_addr), 32'd0);
    @(posedge clk); #1;
    clr = 1'b1;
    scroll_m = 0;
    last_addr_m = '0;
    prime_idle();
    step(202, 150, 1, 1, 1, 0);
    step(203, 150, 1, 1, 1, 0);
    step(204, 150, 1, 0, 1, 0);
    step(205, 150, 1, 1, 1, 0);
    step(0, 0, 1, 1, 1, 0);
    step(0, 84, 1, 1, 1, 0);
    step(0, 395, 1, 1, 1, 0);
    step(9, 96, 1, 1, 1, 0);
    step(640, 500, 0, 1, 1, 0);
    step(640, 500, 0, 1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
